// File: rtl/output_scheduler.sv
// Drain-side frame scheduler: pops frame words from the FIFO, validates them and
// streams 16-bit beats to the addressed output channel under per-channel backpressure.
module output_scheduler #(
  parameter int unsigned NUM_CH    = 8,
  parameter int unsigned MAX_BEATS = 8,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic                           clk_in,
  input  logic                           rst,
  input  logic                           fifo_empty,
  output logic                           fifo_rd_en,
  input  logic [16*MAX_BEATS+NUM_CH+3:0] fifo_rdata,
  input  logic [NUM_CH-1:0]              ch_en,
  input  logic [NUM_CH-1:0]              ch_ready,
  output logic [15:0]                    dout,
  output logic [NUM_CH-1:0]              dout_valid,
  output logic                           frame_done,
  output logic                           fmt_err,
  output logic                           drop,
  output logic                           timeout_err,
  output logic                           busy
);

  localparam int unsigned BEAT_W  = 16;
  localparam int unsigned PAY_W   = BEAT_W * MAX_BEATS;
  localparam int unsigned STALL_W = $clog2(TIMEOUT) + 1;
  localparam logic [3:0]  MAX_LEN = 4'(MAX_BEATS);
  localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, FETCH, CHECK, SEND} state_e;

  state_e               state_q;
  logic [PAY_W-1:0]     payload_q;
  logic [NUM_CH-1:0]    ch_q;
  logic [3:0]           len_q;
  logic [3:0]           beat_q;
  logic [STALL_W-1:0]   stall_q;
  logic [BEAT_W-1:0]    dout_q;
  logic [NUM_CH-1:0]    dout_valid_q;
  logic                 frame_done_q;
  logic                 fmt_err_q;
  logic                 drop_q;
  logic                 timeout_err_q;
  logic                 busy_q;

  logic                 accept_c;
  logic                 last_beat_c;
  logic                 fmt_bad_c;
  logic                 ch_off_c;
  logic [BEAT_W-1:0]    head_beat_c;
  logic [PAY_W-1:0]     payload_shift_c;

  assign fifo_rd_en      = (state_q == IDLE) && !fifo_empty && !rst;
  assign accept_c        = |(dout_valid_q & ch_ready);
  assign last_beat_c     = (beat_q == (len_q - 4'd1));
  assign fmt_bad_c       = !$onehot(ch_q) || (len_q == 4'd0) || (len_q > MAX_LEN);
  assign ch_off_c        = ~|(ch_q & ch_en);
  // Payload is consumed from the top; the remaining beats shift up behind it.
  assign head_beat_c     = payload_q[PAY_W-1 -: BEAT_W];
  assign payload_shift_c = {payload_q[PAY_W-BEAT_W-1:0], {BEAT_W{1'b0}}};

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q       <= IDLE;
      payload_q     <= '0;
      ch_q          <= '0;
      len_q         <= '0;
      beat_q        <= '0;
      stall_q       <= '0;
      dout_q        <= '0;
      dout_valid_q  <= '0;
      frame_done_q  <= 1'b0;
      fmt_err_q     <= 1'b0;
      drop_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      frame_done_q  <= 1'b0;
      fmt_err_q     <= 1'b0;
      drop_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            state_q <= FETCH;
            busy_q  <= 1'b1;
          end
        end
        FETCH: begin
          payload_q <= fifo_rdata[NUM_CH+4 +: PAY_W];
          ch_q      <= fifo_rdata[4 +: NUM_CH];
          len_q     <= fifo_rdata[3:0];
          state_q   <= CHECK;
        end
        CHECK: begin
          if (fmt_bad_c) begin
            fmt_err_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end else if (ch_off_c) begin
            drop_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            beat_q       <= '0;
            stall_q      <= '0;
            dout_q       <= head_beat_c;
            payload_q    <= payload_shift_c;
            dout_valid_q <= ch_q;
            state_q      <= SEND;
          end
        end
        SEND: begin
          if (accept_c) begin
            stall_q <= '0;
            if (last_beat_c) begin
              dout_q       <= '0;
              dout_valid_q <= '0;
              frame_done_q <= 1'b1;
              busy_q       <= 1'b0;
              state_q      <= IDLE;
            end else begin
              beat_q    <= beat_q + 4'd1;
              dout_q    <= head_beat_c;
              payload_q <= payload_shift_c;
            end
          end else if (stall_q >= STALL_LIM) begin
            // Channel stalled for the whole window: abandon the frame.
            dout_q        <= '0;
            dout_valid_q  <= '0;
            timeout_err_q <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= IDLE;
          end else begin
            stall_q <= stall_q + STALL_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dout        = dout_q;
  assign dout_valid  = dout_valid_q;
  assign frame_done  = frame_done_q;
  assign fmt_err     = fmt_err_q;
  assign drop        = drop_q;
  assign timeout_err = timeout_err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_output_scheduler.sv
// Bench for output_scheduler: FIFO model, event monitor, vector tables, corner-case
// sequences and a randomized run checked against a frame-level outcome model.
module tb_output_scheduler;

  localparam int unsigned TMO    = 16;
  localparam logic [2:0]  K_BEAT = 3'd1;
  localparam logic [2:0]  K_DONE = 3'd2;
  localparam logic [2:0]  K_FMT  = 3'd3;
  localparam logic [2:0]  K_DROP = 3'd4;
  localparam logic [2:0]  K_TMO  = 3'd5;

  logic         clk_in     = 1'b0;
  logic         rst        = 1'b1;
  logic         fifo_empty;
  logic         fifo_rd_en;
  logic [139:0] fifo_rdata = '0;
  logic [7:0]   ch_en      = '1;
  logic [7:0]   ch_ready   = '1;
  logic [15:0]  dout;
  logic [7:0]   dout_valid;
  logic         frame_done, fmt_err, drop, timeout_err, busy;

  int checks = 0;
  int errors = 0;

  logic [139:0] fifo_mem [256];
  int           wr_cnt = 0;
  int           rd_cnt = 0;
  logic [26:0]  ev_mem [1024];
  int           ev_wr = 0;
  int           ev_rd = 0;
  logic [26:0]  exp_q [$];

  typedef struct {
    logic [139:0] word;
    logic [7:0]   en;
    logic [2:0]   kind;
    int           beats;
    logic [15:0]  first;
  } vec_t;

  typedef struct {
    logic [7:0]  valid;
    logic [15:0] data;
    logic        done;
    logic        busy;
  } row_t;

  vec_t tbl [12];
  row_t trow [6];

  always #5 clk_in = ~clk_in;

  assign fifo_empty = (wr_cnt == rd_cnt);

  output_scheduler #(.NUM_CH(8), .MAX_BEATS(8), .TIMEOUT(TMO)) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .fifo_empty  (fifo_empty),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_rdata  (fifo_rdata),
    .ch_en       (ch_en),
    .ch_ready    (ch_ready),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .frame_done  (frame_done),
    .fmt_err     (fmt_err),
    .drop        (drop),
    .timeout_err (timeout_err),
    .busy        (busy)
  );

  // FIFO with one-cycle read latency
  always @(posedge clk_in) begin
    if (fifo_rd_en) begin
      fifo_rdata <= fifo_mem[rd_cnt[7:0]];
      rd_cnt     <= rd_cnt + 1;
    end
  end

  // Records accepted beats and outcome pulses as an event stream
  always @(posedge clk_in) begin
    if (!rst) begin
      if ((dout_valid & ch_ready) != 8'h0) begin
        ev_mem[ev_wr[9:0]] <= {K_BEAT, dout_valid, dout};
        ev_wr <= ev_wr + 1;
      end else if (frame_done) begin
        ev_mem[ev_wr[9:0]] <= {K_DONE, 24'h0};
        ev_wr <= ev_wr + 1;
      end else if (fmt_err) begin
        ev_mem[ev_wr[9:0]] <= {K_FMT, 24'h0};
        ev_wr <= ev_wr + 1;
      end else if (drop) begin
        ev_mem[ev_wr[9:0]] <= {K_DROP, 24'h0};
        ev_wr <= ev_wr + 1;
      end else if (timeout_err) begin
        ev_mem[ev_wr[9:0]] <= {K_TMO, 24'h0};
        ev_wr <= ev_wr + 1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic push(input logic [139:0] w);
    fifo_mem[wr_cnt[7:0]] = w;
    wr_cnt = wr_cnt + 1;
  endtask

  function automatic logic [139:0] mk(input logic [127:0] p, input logic [7:0] ch,
                                      input logic [3:0] len);
    return {p, ch, len};
  endfunction

  // Expected outcome of one frame, straight from the word format and channel rules
  function automatic void model(input logic [139:0] w, input logic [7:0] en);
    logic [7:0] ch;
    logic [3:0] len;
    ch  = w[11:4];
    len = w[3:0];
    if ($countones(ch) != 1 || len == 4'd0 || len > 4'd8) begin
      exp_q.push_back({K_FMT, 24'h0});
    end else if ((ch & en) == 8'h0) begin
      exp_q.push_back({K_DROP, 24'h0});
    end else begin
      for (int k = 0; k < int'(len); k++) exp_q.push_back({K_BEAT, ch, w[139-16*k -: 16]});
      exp_q.push_back({K_DONE, 24'h0});
    end
  endfunction

  task automatic compare_events(input string name);
    int n;
    logic [9:0] idx;
    n = ev_wr - ev_rd;
    chk({name, "_event_count"}, 160'(n), 160'(exp_q.size()));
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      idx = 10'(ev_rd + i);
      chk($sformatf("%s_event%0d", name, i), 160'(ev_mem[idx]), 160'(exp_q[i]));
    end
    ev_rd = ev_wr;
    exp_q.delete();
  endtask

  task automatic wait_valid(input string name);
    logic found;
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_in);
      if (dout_valid != 8'h0) begin
        found = 1'b1;
        break;
      end
    end
    chk({name, "_valid_seen"}, 160'(found), 160'(1));
  endtask

  initial begin
    logic [127:0] pa, pb, rp;
    logic [139:0] w;
    logic [7:0]   chv, env, prev_valid, prev_ready;
    logic [15:0]  first, prev_dout;
    logic [3:0]   lenv;
    logic [2:0]   kind;
    logic         seen;
    int           nb, nd, cnt;
    int           t_done [3];

    pa = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    pb = 128'hABCD_0123_4567_89AB_CDEF_FEDC_BA98_7654;

    tbl[0]  = '{mk(pa, 8'h04, 4'd2),  8'hFF, K_DONE, 2, 16'h1111};
    tbl[1]  = '{mk(pa, 8'h06, 4'd3),  8'h00, K_FMT,  0, 16'h0000};
    tbl[2]  = '{mk(pa, 8'h01, 4'd0),  8'hFF, K_FMT,  0, 16'h0000};
    tbl[3]  = '{mk(pa, 8'h01, 4'd9),  8'hFF, K_FMT,  0, 16'h0000};
    tbl[4]  = '{mk(pa, 8'h01, 4'd3),  8'hFE, K_DROP, 0, 16'h0000};
    tbl[5]  = '{mk(pa, 8'h80, 4'd8),  8'hFF, K_DONE, 8, 16'h1111};
    tbl[6]  = '{mk(pa, 8'h00, 4'd1),  8'hFF, K_FMT,  0, 16'h0000};
    tbl[7]  = '{mk(pa, 8'h10, 4'd8),  8'hEF, K_DROP, 0, 16'h0000};
    tbl[8]  = '{mk(pb, 8'h10, 4'd1),  8'h10, K_DONE, 1, 16'hABCD};
    tbl[9]  = '{mk(pa, 8'h01, 4'd15), 8'hFF, K_FMT,  0, 16'h0000};
    tbl[10] = '{mk(pa, 8'h40, 4'd8),  8'h00, K_DROP, 0, 16'h0000};
    tbl[11] = '{mk(pa, 8'h03, 4'd0),  8'hFF, K_FMT,  0, 16'h0000};

    // cycles T+1 .. T+6 after the pop in cycle T, two-beat frame on channel 2
    trow[0] = '{8'h00, 16'h0000, 1'b0, 1'b1};
    trow[1] = '{8'h00, 16'h0000, 1'b0, 1'b1};
    trow[2] = '{8'h04, 16'h1111, 1'b0, 1'b1};
    trow[3] = '{8'h04, 16'h2222, 1'b0, 1'b1};
    trow[4] = '{8'h00, 16'h0000, 1'b1, 1'b0};
    trow[5] = '{8'h00, 16'h0000, 1'b0, 1'b0};

    // Reset with a frame already waiting
    push(mk(pa, 8'h04, 4'd2));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_in);
      chk("rst_rd_en", 160'(fifo_rd_en), 160'(0));
      chk("rst_outputs", 160'({dout, dout_valid, frame_done, fmt_err, drop, timeout_err, busy}), 160'(0));
    end
    rst = 1'b0;
    #1;
    chk("release_rd_en", 160'(fifo_rd_en), 160'(1));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_in);
      chk($sformatf("timing_T+%0d", i + 1), 160'({dout_valid, dout, frame_done, busy}),
          160'({trow[i].valid, trow[i].data, trow[i].done, trow[i].busy}));
    end

    // Frame outcome vectors
    for (int i = 0; i < 12; i++) begin
      ch_en    = tbl[i].en;
      ch_ready = '1;
      push(tbl[i].word);
      kind  = 3'd0;
      nb    = 0;
      first = '0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk_in);
        if ((dout_valid & ch_ready) != 8'h0) begin
          if (nb == 0) first = dout;
          nb++;
        end
        if (frame_done)       kind = K_DONE;
        else if (fmt_err)     kind = K_FMT;
        else if (drop)        kind = K_DROP;
        else if (timeout_err) kind = K_TMO;
        if (kind != 3'd0) break;
      end
      chk($sformatf("vec%0d_outcome", i), 160'(kind), 160'(tbl[i].kind));
      chk($sformatf("vec%0d_beats", i), 160'(nb), 160'(tbl[i].beats));
      chk($sformatf("vec%0d_first", i), 160'(first), 160'(tbl[i].first));
    end
    chk("fifo_drained", 160'(rd_cnt), 160'(wr_cnt));

    // Backpressure on beat 0; other channels' ready must be ignored
    ch_en    = '1;
    ch_ready = 8'hFB;
    push(mk(pa, 8'h04, 4'd2));
    wait_valid("bp");
    for (int j = 0; j < 6; j++) begin
      if (j > 0) @(negedge clk_in);
      chk($sformatf("bp_hold%0d", j), 160'({dout_valid, dout}), 160'({8'h04, 16'h1111}));
    end
    ch_ready = '1;
    @(negedge clk_in);
    chk("bp_beat1", 160'({dout_valid, dout, frame_done}), 160'({8'h04, 16'h2222, 1'b0}));
    @(negedge clk_in);
    chk("bp_done", 160'({dout_valid, frame_done}), 160'({8'h00, 1'b1}));

    // Stall timeout, then the next queued frame must still go out
    ch_ready = 8'h7F;
    push(mk(pa, 8'h80, 4'd3));
    push(mk(pb, 8'h04, 4'd1));
    wait_valid("tmo");
    cnt  = 0;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (dout_valid == 8'h80) cnt++;
      if (timeout_err) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk_in);
    end
    chk("tmo_pulse", 160'(seen), 160'(1));
    chk("tmo_valid_cycles", 160'(cnt), 160'(TMO));
    chk("tmo_outputs", 160'({dout_valid, frame_done}), 160'(0));
    chk("tmo_next_pop", 160'(fifo_rd_en), 160'(1));
    ch_ready = '1;
    first = '0;
    seen  = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_in);
      if ((dout_valid & ch_ready) != 8'h0) first = dout;
      if (frame_done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("tmo_next_done", 160'(seen), 160'(1));
    chk("tmo_next_beat", 160'(first), 160'(16'hABCD));

    // Reset in the middle of a frame discards it silently
    ch_ready = '0;
    push(mk(pa, 8'h04, 4'd2));
    wait_valid("midrst");
    rst = 1'b1;
    @(negedge clk_in);
    chk("midrst_outputs", 160'({dout, dout_valid, busy}), 160'(0));
    rst      = 1'b0;
    ch_ready = '1;
    seen     = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_in);
      if (frame_done || fmt_err || drop || timeout_err || dout_valid != 8'h0) seen = 1'b1;
    end
    chk("midrst_quiet", 160'(seen), 160'(0));

    // Three queued full frames back to back
    ev_rd = ev_wr;
    exp_q.delete();
    ch_en    = '1;
    ch_ready = '1;
    for (int f = 0; f < 3; f++) begin
      rp = {$urandom(), $urandom(), $urandom(), $urandom()};
      w  = mk(rp, 8'(1 << $urandom_range(0, 7)), 4'd8);
      model(w, 8'hFF);
      push(w);
    end
    nd = 0;
    t_done = '{0, 0, 0};
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(negedge clk_in);
      if (frame_done && nd < 3) begin
        t_done[nd] = cyc;
        nd++;
      end
      if (nd == 3) break;
    end
    chk("b2b_frames", 160'(nd), 160'(3));
    chk("b2b_gap1", 160'(t_done[1] - t_done[0]), 160'(11));
    chk("b2b_gap2", 160'(t_done[2] - t_done[1]), 160'(11));
    @(negedge clk_in);
    compare_events("b2b");

    // Randomized frames with random backpressure
    for (int f = 0; f < 40; f++) begin
      rp = {$urandom(), $urandom(), $urandom(), $urandom()};
      if ($urandom_range(0, 4) == 0) chv = 8'($urandom());
      else                           chv = 8'(1 << $urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) lenv = 4'($urandom_range(0, 15));
      else                           lenv = 4'($urandom_range(1, 8));
      if ($urandom_range(0, 3) == 0) env = 8'($urandom());
      else                           env = 8'hFF;
      w     = mk(rp, chv, lenv);
      ch_en = env;
      model(w, env);
      push(w);
      prev_valid = '0;
      prev_ready = '0;
      prev_dout  = '0;
      seen       = 1'b0;
      for (int c = 0; c < 400; c++) begin
        @(negedge clk_in);
        chk("rand_valid_onehot0", 160'($onehot0(dout_valid)), 160'(1));
        if (prev_valid != 8'h0 && (prev_valid & prev_ready) == 8'h0)
          chk("rand_hold", 160'({dout_valid, dout}), 160'({prev_valid, prev_dout}));
        if (busy) seen = 1'b1;
        prev_valid = dout_valid;
        prev_dout  = dout;
        for (int b = 0; b < 8; b++) ch_ready[b] = ($urandom_range(0, 7) != 0);
        prev_ready = ch_ready;
        if (seen && !busy) break;
      end
      chk($sformatf("rand%0d_finished", f), 160'(seen && !busy), 160'(1));
    end
    @(negedge clk_in);
    compare_events("rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
